// File: rtl/logicunit_arbiter.sv
// logicunit_arbiter: round-robin sharing of one logicunit between two requesters with a held response
module logicunit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [1:0]       ctl0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       ctl1,
  output logic             gnt1,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [1:0]       lu_ctl,
  input  logic [WIDTH-1:0] lu_out,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic             busy,
  output logic [7:0]       ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q, state_d;
  logic             pri_q, pri_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [1:0]       ctl_q, ctl_d;
  logic             id_q, id_d, valid_q, valid_d, rid_q, rid_d;
  logic [7:0]       ops_q, ops_d;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pri_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctl_q   <= '0;
      id_q    <= 1'b0;
      valid_q <= 1'b0;
      rid_q   <= 1'b0;
      data_q  <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctl_q   <= ctl_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      rid_q   <= rid_d;
      data_q  <= data_d;
      ops_q   <= ops_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && (gnt0 || gnt1)) state_d = EXEC;
    else if (state_q == EXEC) state_d = RESP;
    else if (state_q == RESP && rsp_ready) state_d = IDLE;
  end
  // pri_q names the requester that wins a tie, i.e. the one not served last
  always_comb begin
    gnt0    = state_q == IDLE && req0 && (!req1 || !pri_q);
    gnt1    = state_q == IDLE && req1 && (!req0 || pri_q);
    pri_d   = gnt0 ? 1'b1 : gnt1 ? 1'b0 : pri_q;
    a_d     = gnt0 ? a0 : gnt1 ? a1 : a_q;
    b_d     = gnt0 ? b0 : gnt1 ? b1 : b_q;
    ctl_d   = gnt0 ? ctl0 : gnt1 ? ctl1 : ctl_q;
    id_d    = gnt0 ? 1'b0 : gnt1 ? 1'b1 : id_q;
    valid_d = state_q == EXEC ? 1'b1 : state_q == RESP && rsp_ready ? 1'b0 : valid_q;
    rid_d   = state_q == EXEC ? id_q : rid_q;
    data_d  = state_q == EXEC ? lu_out : data_q;
    ops_d   = state_q == RESP && rsp_ready ? ops_q + 8'd1 : ops_q;
    lu_a    = state_q == EXEC ? a_q : '0;
    lu_b    = state_q == EXEC ? b_q : '0;
    lu_ctl  = state_q == EXEC ? ctl_q : 2'd0;
    busy    = state_q != IDLE;
  end
  assign rsp_valid = valid_q;
  assign rsp_id    = rid_q;
  assign rsp_data  = data_q;
  assign ops_done  = ops_q;
endmodule

// File: tb/tb_logicunit_arbiter.sv
// tb_logicunit_arbiter: directed checks of arbitration, latency, backpressure, reset and counter wrap
module tb_logicunit_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req0 = 0, req1 = 0, rsp_ready = 0;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [1:0]  ctl0 = 0, ctl1 = 0;
  logic        gnt0, gnt1, rsp_valid, rsp_id, busy;
  logic [31:0] lu_a, lu_b, lu_out, rsp_data;
  logic [1:0]  lu_ctl;
  logic [7:0]  ops_done;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  always_comb
    case (lu_ctl)
      2'd0:    lu_out = lu_a & lu_b;
      2'd1:    lu_out = lu_a | lu_b;
      2'd2:    lu_out = ~(lu_a | lu_b);
      default: lu_out = lu_a ^ lu_b;
    endcase
  logicunit_arbiter #(.WIDTH(32)) dut (
    .clock(clk), .reset(rst),
    .req0(req0), .a0(a0), .b0(b0), .ctl0(ctl0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .ctl1(ctl1), .gnt1(gnt1),
    .lu_a(lu_a), .lu_b(lu_b), .lu_ctl(lu_ctl), .lu_out(lu_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy), .ops_done(ops_done)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic finish_op(input logic id, input logic [31:0] exp);
    for (int k = 0; k < 8 && !rsp_valid; k++) @(negedge clk);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_id", rsp_id, id);
    check("rsp_data", rsp_data, exp);
    check("lu_a_idle", lu_a, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("busy_idle", busy, 0);
  endtask
  task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] ctl, input logic [31:0] exp);
    @(negedge clk);
    if (id) begin req1 = 1; a1 = a; b1 = b; ctl1 = ctl; end
    else    begin req0 = 1; a0 = a; b0 = b; ctl0 = ctl; end
    #1;
    for (int k = 0; k < 8 && !(id ? gnt1 : gnt0); k++) begin @(negedge clk); #1; end
    check("gnt_mine", id ? gnt1 : gnt0, 1);
    check("gnt_other", id ? gnt0 : gnt1, 0);
    @(posedge clk);
    @(negedge clk);
    req0 = 0; req1 = 0;
    a0 = ~a; b0 = ~b; a1 = ~a; b1 = ~b; ctl0 = ~ctl; ctl1 = ~ctl;
    check("busy_exec", busy, 1);
    check("lu_a", lu_a, a);
    check("lu_b", lu_b, b);
    check("lu_ctl", lu_ctl, ctl);
    check("rsp_early", rsp_valid, 0);
    finish_op(id, exp);
  endtask
  initial begin
    do_reset();
    check("rst_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ops", ops_done, 0);
    check("rst_data", rsp_data, 0);
    check("rst_gnt", {gnt0, gnt1}, 0);
    check("rst_lu", {lu_a, lu_b}, 0);
    run_op(0, 32'h0000FFFF, 32'h00FF00FF, 2'd0, 32'h000000FF);
    check("ops_1", ops_done, 1);
    run_op(1, 32'hF0F0F0F0, 32'hFF00FF00, 2'd0, 32'hF000F000);
    run_op(1, 32'hF0F0F0F0, 32'hFF00FF00, 2'd1, 32'hFFF0FFF0);
    run_op(1, 32'hF0F0F0F0, 32'hFF00FF00, 2'd2, 32'h000F000F);
    run_op(1, 32'hF0F0F0F0, 32'hFF00FF00, 2'd3, 32'h0FF00FF0);
    check("ops_5", ops_done, 5);
    // round robin: grants expected at cycles 0,3,6,9 in order 0,1,0,1
    do_reset();
    @(negedge clk);
    req0 = 1; req1 = 1; rsp_ready = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("rr_g0", gnt0, (i % 6) == 0);
      check("rr_g1", gnt1, (i % 6) == 3);
      @(negedge clk);
    end
    req0 = 0; req1 = 0; rsp_ready = 0;
    check("rr_ops", ops_done, 4);
    // backpressure
    @(negedge clk);
    req1 = 1; a1 = 32'h12345678; b1 = 32'h0F0F0000; ctl1 = 2'd1;
    #1 check("bp_gnt", gnt1, 1);
    @(posedge clk);
    @(negedge clk);
    req1 = 0; req0 = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 32'h1F3F5678);
      check("bp_id", rsp_id, 1);
      check("bp_busy", busy, 1);
      check("bp_nognt", {gnt0, gnt1}, 0);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    req0 = 0; rsp_ready = 0;
    check("bp_ops", ops_done, 5);
    check("bp_done", rsp_valid, 0);
    // reset in EXEC after serving 0, so the tie must fall back to 0 only through reset
    @(negedge clk);
    req0 = 1; a0 = 32'hFFFFFFFF; b0 = 32'hFFFFFFFF;
    #1 check("mr_gnt", gnt0, 1);
    @(posedge clk);
    @(negedge clk);
    req0 = 0; rst = 1;
    check("mr_exec", busy, 1);
    @(negedge clk);
    rst = 0;
    check("mr_valid", rsp_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_ops", ops_done, 0);
    repeat (2) @(negedge clk);
    check("mr_novalid", rsp_valid, 0);
    req0 = 1; req1 = 1; a0 = 32'h00000003; b0 = 32'h00000005; ctl0 = 2'd3;
    #1;
    check("mr_tie0", gnt0, 1);
    check("mr_tie1", gnt1, 0);
    @(posedge clk);
    @(negedge clk);
    req0 = 0; req1 = 0;
    finish_op(0, 32'h00000006);
    // counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      run_op(i[0], 32'hF0F0F0F0, 32'hFF00FF00, 2'd3, 32'h0FF00FF0);
      if (i == 254) check("wrap_255", ops_done, 255);
    end
    check("wrap_0", ops_done, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/logicunit_arbiter.md
Name: logicunit_arbiter

Overview:
- Shares one combinational logicunit (2-bit control: 0=AND, 1=OR, 2=NOR, 3=XOR) between two requesters.
- Grants requests round-robin, latches the winner's operands, drives the shared unit for one cycle, registers the result, and holds it on a response port until it is accepted.
- Sits between the two client datapaths and the single logicunit instance.

Parameters:
WIDTH, 32, operand/result width in bits (logicunit instantiated at this width)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 has an operation pending
a0  input  WIDTH  requester 0 operand A
b0  input  WIDTH  requester 0 operand B
ctl0  input  2  requester 0 logicunit control
gnt0  output  1  requester 0 operation accepted this cycle
req1  input  1  requester 1 has an operation pending
a1  input  WIDTH  requester 1 operand A
b1  input  WIDTH  requester 1 operand B
ctl1  input  2  requester 1 logicunit control
gnt1  output  1  requester 1 operation accepted this cycle
lu_a  output  WIDTH  operand A to shared logicunit
lu_b  output  WIDTH  operand B to shared logicunit
lu_ctl  output  2  control to shared logicunit
lu_out  input  WIDTH  result from shared logicunit
rsp_valid  output  1  response holds a valid result
rsp_id  output  1  requester that owns the response
rsp_data  output  WIDTH  registered result
rsp_ready  input  1  consumer accepts response
busy  output  1  high in any state except IDLE
ops_done  output  8  completed-response counter, wraps 255->0

Behaviour:
- States: IDLE, EXEC, RESP. Reset -> IDLE. Encoding is free.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, ops_done=0, busy=0, gnt0=gnt1=0, operand/ctl latches=0, lu_a=lu_b=0, lu_ctl=0, rr pointer favours requester 0.
- gnt0/gnt1 are combinational. They may be high only in IDLE and never together. An operation transfers on the edge where req_i && gnt_i.
- Arbitration in IDLE:
  - Only one req high: grant it.
  - Both high: grant the requester not served last. After reset, requester 0 wins the first tie.
  - On grant: rr pointer records the winner; a/b/ctl and id are latched; next state is EXEC.
- EXEC (exactly 1 cycle): lu_a/lu_b/lu_ctl drive the latched values. On the edge, rsp_data<=lu_out, rsp_id<=latched id, rsp_valid<=1, next state RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data stay stable until the edge where rsp_ready=1.
  - On that edge: rsp_valid<=0, ops_done<=ops_done+1 (mod 256), next state IDLE.
  - No new grant is issued in RESP, even if rsp_ready=1 and requests are pending.
- lu_a/lu_b/lu_ctl are 0 outside EXEC, so the shared unit's inputs are deterministic.
- Latency: grant edge N -> rsp_valid high from cycle N+2. Minimum 3 cycles per operation (IDLE, EXEC, RESP with rsp_ready already high).
- Requester inputs may change freely after the grant edge; the latched copy is used.
- req deasserted in IDLE: no grant, no state change, rr pointer unchanged.
- rsp_ready high while rsp_valid=0: ignored.
- Reset asserted in EXEC or RESP: the in-flight operation is discarded, no response is produced, all state returns to reset values next edge. ops_done clears.
- Fairness: with both reqs held high continuously, grants strictly alternate 0,1,0,1...

Test Plan:
- Single op: reset, then req0=1, a0=0x0000FFFF, b0=0x00FF00FF, ctl0=0 (AND) -> gnt0 high in IDLE; rsp_valid rises 2 cycles after grant with rsp_data=0x000000FF, rsp_id=0; rsp_ready=1 -> ops_done=1, back to IDLE.
- All controls: requester 1 issues ctl=0,1,2,3 in turn with a1=0xF0F0F0F0, b1=0xFF00FF00 -> rsp_data=0xF000F000, 0xFFF0FFF0, 0x000F000F, 0x0FF00FF0, rsp_id=1 each time.
- Round-robin: req0=req1=1 held, rsp_ready=1 -> grant order 0,1,0,1; never both gnt in one cycle; 4 responses after 12 cycles, ops_done=4.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_id stable, no grants, busy=1; then rsp_ready=1 -> one completion, ops_done increments once.
- Reset mid-operation: reset asserted in EXEC -> next cycle rsp_valid=0, busy=0, ops_done=0; rsp_valid never rises for the dropped op; the next tie grants requester 0.
- Counter wrap: complete 256 operations -> ops_done returns to 0.
